vov_accumulator: RTL and testbench

VOV_ACCUMULATOR -- requirements
Module: vov_accumulator

---
 rtl/vov_accumulator_pkg.sv | 21 ++
 rtl/vov_accumulator_if.sv | 29 ++
 rtl/vov_result_fifo.sv | 60 ++++++
 rtl/vov_accumulator.sv | 141 ++++++++++++++
 tb/tb_vov_accumulator.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/vov_accumulator_pkg.sv
// Shared definitions for the vov accumulator slice: width helpers,
// result entry sizing and FSM state encoding.
package vov_pkg;

    localparam int VOV_W = 4;

    function automatic int calc_sum_w(input int k, input int groups);
        return $clog2(k * groups + 1);
    endfunction

    // Result entry is {act, sum}
    function automatic int entry_w(input int sum_w);
        return 1 + sum_w;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } vov_state_e;

endpackage

// File: rtl/vov_accumulator_if.sv
// Bus between the upstream group reducer / downstream consumer and the
// neuron accumulator.
interface vov_accumulator_if #(
    parameter int SUM_W = 8
);
    import vov_pkg::*;

    logic [VOV_W-1:0] vov_in;
    logic             vov_valid;
    logic [SUM_W-1:0] thr;
    logic             thr_load;
    logic             out_ready;
    logic             out_valid;
    logic             act_out;
    logic [SUM_W-1:0] sum_out;
    logic             busy;
    logic             ovf;

    modport master (
        output vov_in, vov_valid, thr, thr_load, out_ready,
        input  out_valid, act_out, sum_out, busy, ovf
    );

    modport slave (
        input  vov_in, vov_valid, thr, thr_load, out_ready,
        output out_valid, act_out, sum_out, busy, ovf
    );

endinterface

// File: rtl/vov_result_fifo.sv
// Two-entry result FIFO with registered storage; a push is accepted when
// full only if a pop happens in the same cycle.
module vov_result_fifo
    import vov_pkg::*;
#(
    parameter int ENTRY_W = entry_w(8)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] rdata_o,
    output logic               full_o,
    output logic               empty_o
);

    logic [ENTRY_W-1:0] mem_q [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         count_q;
    logic               push_en_s;
    logic               pop_en_s;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign rdata_o = mem_q[rd_ptr_q];

    // Qualify requests against occupancy
    always_comb begin
        pop_en_s  = pop_i && !empty_o;
        push_en_s = push_i && (!full_o || pop_en_s);
    end

    // Storage, pointers and occupancy; when full, a push overwrites the slot
    // being popped, which is safe because the head is read before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_en_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_en_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vov_accumulator.sv
// Sums GROUPS group popcounts into one neuron sum, thresholds it against the
// threshold captured at neuron start, and queues {act, sum} for the consumer.
module vov_accumulator
    import vov_pkg::*;
#(
    parameter int K      = 4,
    parameter int GROUPS = 16,
    parameter int SUM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    vov_accumulator_if.slave  bus
);

    localparam int              G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int              E_W    = entry_w(SUM_W);
    localparam logic [G_W-1:0]  G_LAST = G_W'(GROUPS - 1);

    vov_state_e       state_q;
    logic [G_W-1:0]   g_q;
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] shadow_q;
    logic [SUM_W-1:0] thr_act_q;
    logic             ovf_q;

    logic [VOV_W-1:0] vov_clamped_s;
    logic [SUM_W-1:0] vov_ext_s;
    logic [SUM_W-1:0] thr_start_s;
    logic [SUM_W-1:0] base_s;
    logic [SUM_W-1:0] final_s;
    logic [SUM_W-1:0] cmp_thr_s;
    logic             last_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic [E_W-1:0]   head_s;
    logic             full_s;
    logic             empty_s;

    // Operand selection; a thr_load coinciding with neuron start wins over the shadow
    always_comb begin
        if (bus.vov_in > VOV_W'(K)) begin
            vov_clamped_s = VOV_W'(K);
        end else begin
            vov_clamped_s = bus.vov_in;
        end
        vov_ext_s = SUM_W'(vov_clamped_s);
        if (bus.thr_load) begin
            thr_start_s = bus.thr;
        end else begin
            thr_start_s = shadow_q;
        end
        if (state_q == ST_ACCUM) begin
            base_s    = sum_q;
            cmp_thr_s = thr_act_q;
            last_s    = (g_q == G_LAST);
        end else begin
            base_s    = '0;
            cmp_thr_s = thr_start_s;
            last_s    = (GROUPS == 1);
        end
        final_s = base_s + vov_ext_s;
        push_s  = bus.vov_valid && last_s;
        pop_s   = !empty_s && bus.out_ready;
        drop_s  = push_s && full_s && !pop_s;
    end

    vov_result_fifo #(
        .ENTRY_W (E_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .wdata_i ({(final_s >= cmp_thr_s), final_s}),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Neuron FSM, threshold shadow/active registers and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            g_q       <= '0;
            sum_q     <= '0;
            shadow_q  <= '0;
            thr_act_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (bus.thr_load) begin
                shadow_q <= bus.thr;
            end
            if (drop_s) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.vov_valid && !push_s) begin
                        sum_q     <= vov_ext_s;
                        g_q       <= G_W'(1);
                        thr_act_q <= thr_start_s;
                        state_q   <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (bus.vov_valid) begin
                        if (push_s) begin
                            sum_q   <= '0;
                            g_q     <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            sum_q <= final_s;
                            g_q   <= g_q + G_W'(1);
                        end
                    end
                end
                default: begin
                    sum_q   <= '0;
                    g_q     <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs read as zero whenever no entry is queued
    always_comb begin
        bus.out_valid = !empty_s;
        bus.busy      = (state_q == ST_ACCUM);
        bus.ovf       = ovf_q;
        if (empty_s) begin
            bus.act_out = 1'b0;
            bus.sum_out = '0;
        end else begin
            bus.act_out = head_s[SUM_W];
            bus.sum_out = head_s[SUM_W-1:0];
        end
    end

endmodule

// File: tb/tb_vov_accumulator.sv
// Directed bench for vov_accumulator with K=4, GROUPS=4, SUM_W=8.
module tb_vov_accumulator;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    vov_accumulator_if #(.SUM_W(8)) bus ();

    vov_accumulator #(
        .K      (4),
        .GROUPS (4),
        .SUM_W  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] v);
        bus.vov_valid = 1'b1;
        bus.vov_in    = v;
        tick();
    endtask

    task automatic load_thr(input logic [7:0] t);
        bus.thr      = t;
        bus.thr_load = 1'b1;
        tick();
        bus.thr_load = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.vov_in    = 4'd0;
        bus.vov_valid = 1'b0;
        bus.thr       = 8'd0;
        bus.thr_load  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_sum_out",   16'(bus.sum_out),   16'd0);
        chk("rst_busy",      16'(bus.busy),      16'd0);
        chk("rst_ovf",       16'(bus.ovf),       16'd0);
        rst_n = 1'b1;
        tick();

        // Contiguous neuron 1+2+3+4 = 10 against threshold 10
        bus.out_ready = 1'b1;
        load_thr(8'd10);
        send(4'd1);
        chk("t1_busy", 16'(bus.busy), 16'd1);
        send(4'd2);
        send(4'd3);
        send(4'd4);
        bus.vov_valid = 1'b0;
        chk("t1_out_valid", 16'(bus.out_valid), 16'd1);
        chk("t1_sum",       16'(bus.sum_out),   16'd10);
        chk("t1_act",       16'(bus.act_out),   16'd1);
        chk("t1_busy_done", 16'(bus.busy),      16'd0);
        tick();
        chk("t1_popped", 16'(bus.out_valid), 16'd0);

        // Gap of 5 cycles mid-neuron, 4+0+3+3 = 10 against threshold 11
        load_thr(8'd11);
        send(4'd4);
        send(4'd0);
        bus.vov_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_gap_busy", 16'(bus.busy), 16'd1);
        end
        send(4'd3);
        send(4'd3);
        bus.vov_valid = 1'b0;
        chk("t2_out_valid", 16'(bus.out_valid), 16'd1);
        chk("t2_sum",       16'(bus.sum_out),   16'd10);
        chk("t2_act",       16'(bus.act_out),   16'd0);
        tick();
        chk("t2_popped", 16'(bus.out_valid), 16'd0);

        // Three neurons of 4s with the consumer stalled: third result is dropped
        bus.out_ready = 1'b0;
        load_thr(8'd0);
        for (int i = 0; i < 8; i++) send(4'd4);
        bus.vov_valid = 1'b0;
        chk("t3_ovf_before", 16'(bus.ovf),     16'd0);
        chk("t3_sum_two",    16'(bus.sum_out), 16'd16);
        for (int i = 0; i < 4; i++) send(4'd4);
        bus.vov_valid = 1'b0;
        chk("t3_ovf",       16'(bus.ovf),       16'd1);
        chk("t3_out_valid", 16'(bus.out_valid), 16'd1);
        chk("t3_sum",       16'(bus.sum_out),   16'd16);
        chk("t3_act",       16'(bus.act_out),   16'd1);
        tick();
        tick();
        chk("t3_held_valid", 16'(bus.out_valid), 16'd1);
        chk("t3_held_sum",   16'(bus.sum_out),   16'd16);
        bus.out_ready = 1'b1;
        tick();
        chk("t3_pop1_valid", 16'(bus.out_valid), 16'd1);
        chk("t3_pop1_sum",   16'(bus.sum_out),   16'd16);
        tick();
        chk("t3_pop2_empty", 16'(bus.out_valid), 16'd0);
        chk("t3_ovf_sticky", 16'(bus.ovf),       16'd1);

        // Mid-neuron thr_load only affects the next neuron
        load_thr(8'd5);
        send(4'd2);
        bus.thr      = 8'd20;
        bus.thr_load = 1'b1;
        send(4'd2);
        bus.thr_load = 1'b0;
        send(4'd2);
        send(4'd2);
        bus.vov_valid = 1'b0;
        chk("t4_sum_a", 16'(bus.sum_out), 16'd8);
        chk("t4_act_a", 16'(bus.act_out), 16'd1);
        tick();
        for (int i = 0; i < 4; i++) send(4'd2);
        bus.vov_valid = 1'b0;
        chk("t4_sum_b", 16'(bus.sum_out), 16'd8);
        chk("t4_act_b", 16'(bus.act_out), 16'd0);
        tick();
        // thr_load together with the first group applies to that neuron
        bus.thr      = 8'd8;
        bus.thr_load = 1'b1;
        send(4'd2);
        bus.thr_load = 1'b0;
        for (int i = 0; i < 3; i++) send(4'd2);
        bus.vov_valid = 1'b0;
        chk("t4_sum_c", 16'(bus.sum_out), 16'd8);
        chk("t4_act_c", 16'(bus.act_out), 16'd1);
        tick();

        // Reset mid-neuron discards the partial sum and clears ovf
        send(4'd4);
        send(4'd4);
        bus.vov_valid = 1'b0;
        chk("t5_busy_pre", 16'(bus.busy), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_busy", 16'(bus.busy),      16'd0);
        chk("t5_async_ovf",  16'(bus.ovf),       16'd0);
        chk("t5_async_ov",   16'(bus.out_valid), 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send(4'd1);
        bus.vov_valid = 1'b0;
        chk("t5_out_valid", 16'(bus.out_valid), 16'd1);
        chk("t5_sum",       16'(bus.sum_out),   16'd4);
        chk("t5_act",       16'(bus.act_out),   16'd1);
        chk("t5_ovf",       16'(bus.ovf),       16'd0);
        tick();
        chk("t5_no_stale", 16'(bus.out_valid), 16'd0);

        // Full FIFO with simultaneous pop and push keeps every result in order
        bus.out_ready = 1'b0;
        load_thr(8'd6);
        for (int i = 0; i < 4; i++) send(4'd1);
        for (int i = 0; i < 4; i++) send(4'd2);
        bus.vov_valid = 1'b0;
        chk("t6_head_a_sum", 16'(bus.sum_out), 16'd4);
        chk("t6_head_a_act", 16'(bus.act_out), 16'd0);
        for (int i = 0; i < 3; i++) send(4'd3);
        bus.out_ready = 1'b1;
        send(4'd3);
        bus.vov_valid = 1'b0;
        chk("t6_ovf",        16'(bus.ovf),       16'd0);
        chk("t6_out_valid",  16'(bus.out_valid), 16'd1);
        chk("t6_head_b_sum", 16'(bus.sum_out),   16'd8);
        chk("t6_head_b_act", 16'(bus.act_out),   16'd1);
        tick();
        chk("t6_head_c_sum", 16'(bus.sum_out), 16'd12);
        chk("t6_head_c_act", 16'(bus.act_out), 16'd1);
        tick();
        chk("t6_empty",     16'(bus.out_valid), 16'd0);
        chk("t6_ovf_final", 16'(bus.ovf),       16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
